sprite_anim_ram: RTL and testbench

//  Parametrised multi-frame sprite memory for tower/enemy graphics: NUM_FRAMES frames of WIDTH x HEIGHT 24-bit RGB.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_anim_seq.sv | 60 ++++++
 rtl/sprite_anim_ram.sv | 149 ++++++++++++++
 tb/tb_sprite_anim_ram.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// ----------------------------------------------------------------------------
// sprite_pkg
// Shared types and constants for the sprite animation memory.
//   pixel_t        : 24-bit RGB pixel (R in [23:16], G in [15:8], B in [7:0])
//   sprite_coord_t : 10-bit sprite-local coordinate
//   PIXEL_BLACK    : value returned for out-of-bounds requests
// ----------------------------------------------------------------------------
package sprite_pkg;

    typedef logic [23:0] pixel_t;
    typedef logic [9:0]  sprite_coord_t;

    localparam pixel_t PIXEL_BLACK = 24'h0;

endpackage

// File: rtl/sprite_anim_seq.sv
// ----------------------------------------------------------------------------
// sprite_anim_seq
// Animation frame sequencer. Each frame is shown for FRAME_HOLD vsync ticks,
// then the sequencer moves on to the next frame, wrapping after NUM_FRAMES.
// Ports:
//   Clk          in   system clock (posedge)
//   Reset        in   synchronous active-high reset
//   vsync_tick   in   one-cycle pulse per video frame
//   anim_en      in   1 = advance on vsync_tick, 0 = freeze frame and hold
//   anim_restart in   force frame 0 / hold 0 (wins over vsync_tick)
//   cur_frame    out  frame currently displayed
// ----------------------------------------------------------------------------
module sprite_anim_seq #(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          vsync_tick,
    input  logic          anim_en,
    input  logic          anim_restart,
    output logic [FW-1:0] cur_frame
);

    logic [HW-1:0] hold_reg, hold_next;
    logic [FW-1:0] frame_reg, frame_next;

    always_comb begin
        hold_next  = hold_reg;
        frame_next = frame_reg;
        if (anim_restart) begin
            hold_next  = '0;
            frame_next = '0;
        end else if (vsync_tick && anim_en) begin
            if (32'(hold_reg) == FRAME_HOLD - 1) begin
                hold_next  = '0;
                // With a single frame this comparison is always true, so
                // the frame index stays pinned at 0.
                frame_next = (32'(frame_reg) == NUM_FRAMES - 1) ? '0 : frame_reg + FW'(1);
            end else begin
                hold_next = hold_reg + HW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_reg  <= '0;
            frame_reg <= '0;
        end else begin
            hold_reg  <= hold_next;
            frame_reg <= frame_next;
        end
    end

    assign cur_frame = frame_reg;

endmodule

// File: rtl/sprite_anim_ram.sv
// ----------------------------------------------------------------------------
// sprite_anim_ram
// Multi-frame sprite memory: NUM_FRAMES frames of WIDTH x HEIGHT RGB pixels
// stored back-to-back. A sprite-local (x,y) request is turned into a
// two-stage pipelined read from the current animation frame; out-of-bounds
// coordinates return black. CPU-writable.
//
// Optional feature macro: SPRITE_TRANSPARENCY_EN
//   defined     : rd_opaque = rd_in_bounds && (pixel != TRANSP_KEY)
//   not defined : rd_opaque = rd_in_bounds
//
// Ports:
//   Clk, Reset        clock / synchronous active-high reset
//   vsync_tick        one-cycle pulse per video frame
//   anim_en           sequencer advances on vsync_tick when 1
//   anim_restart      force frame 0, hold count 0
//   rd_req, rd_x, rd_y  read request and sprite-local coordinates
//   rd_valid          response valid (rd_req delayed two cycles)
//   data_Out          RGB pixel
//   rd_in_bounds      request was inside WIDTH x HEIGHT
//   rd_opaque         pixel should be drawn
//   we, write_address, data_In  write port (flat address)
//   cur_frame         frame currently displayed
// ----------------------------------------------------------------------------
module sprite_anim_ram
    import sprite_pkg::*;
#(
    parameter int          WIDTH      = 50,
    parameter int          HEIGHT     = 50,
    parameter int          NUM_FRAMES = 4,
    parameter int          FRAME_HOLD = 8,
    parameter              INIT_FILE  = "",
    parameter logic [23:0] TRANSP_KEY = 24'hFF00FF,
    localparam int DEPTH = WIDTH * HEIGHT * NUM_FRAMES,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          vsync_tick,
    input  logic          anim_en,
    input  logic          anim_restart,
    input  logic          rd_req,
    input  logic [9:0]    rd_x,
    input  logic [9:0]    rd_y,
    output logic          rd_valid,
    output logic [23:0]   data_Out,
    output logic          rd_in_bounds,
    output logic          rd_opaque,
    input  logic          we,
    input  logic [AW-1:0] write_address,
    input  logic [23:0]   data_In,
    output logic [FW-1:0] cur_frame
);

    // ---------------- frame sequencer ----------------
    sprite_anim_seq #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_seq (
        .Clk          (Clk),
        .Reset        (Reset),
        .vsync_tick   (vsync_tick),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .cur_frame    (cur_frame)
    );

    // ---------------- pixel storage ----------------
    pixel_t mem [DEPTH];

    // Write port; addresses past the last frame are dropped.
    always_ff @(posedge Clk) begin
        if (we && (32'(write_address) < DEPTH)) begin
            mem[write_address] <= data_In;
        end
    end

    // ---------------- stage 1: bounds check + address ----------------
    logic          req_in_bounds;
    logic [AW-1:0] req_addr;

    always_comb begin
        req_in_bounds = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
        req_addr      = '0;
        // Out-of-bounds requests park on address 0 so the RAM is never
        // indexed past DEPTH-1; their data is replaced by black later.
        if (req_in_bounds) begin
            req_addr = AW'(cur_frame) * AW'(WIDTH * HEIGHT)
                     + AW'(rd_y) * AW'(WIDTH)
                     + AW'(rd_x);
        end
    end

    logic          s1_valid_reg;
    logic          s1_in_bounds_reg;
    logic [AW-1:0] s1_addr_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_reg     <= 1'b0;
            s1_in_bounds_reg <= 1'b0;
            s1_addr_reg      <= '0;
        end else begin
            s1_valid_reg <= rd_req;
            if (rd_req) begin
                s1_in_bounds_reg <= req_in_bounds;
                s1_addr_reg      <= req_addr;
            end
        end
    end

    // ---------------- stage 2: registered RAM read ----------------
    // Read and write share the clock edge; the non-blocking write means a
    // same-address collision returns the previous contents.
    logic   rd_valid_reg;
    pixel_t data_out_reg;
    logic   rd_in_bounds_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid_reg     <= 1'b0;
            data_out_reg     <= PIXEL_BLACK;
            rd_in_bounds_reg <= 1'b0;
        end else begin
            rd_valid_reg <= s1_valid_reg;
            // Data and flags only move on a real request, otherwise they hold.
            if (s1_valid_reg) begin
                rd_in_bounds_reg <= s1_in_bounds_reg;
                data_out_reg     <= s1_in_bounds_reg ? mem[s1_addr_reg] : PIXEL_BLACK;
            end
        end
    end

    assign rd_valid     = rd_valid_reg;
    assign data_Out     = data_out_reg;
    assign rd_in_bounds = rd_in_bounds_reg;

    // Derived from the registered pixel so it tracks data_Out exactly,
    // including the hold behaviour between requests.
`ifdef SPRITE_TRANSPARENCY_EN
    assign rd_opaque = rd_in_bounds_reg && (data_out_reg != TRANSP_KEY);
`else
    logic [23:0] unused_transp_key;
    assign unused_transp_key = TRANSP_KEY;
    assign rd_opaque         = rd_in_bounds_reg;
`endif

endmodule

// File: tb/tb_sprite_anim_ram.sv
module tb_sprite_anim_ram;

    localparam int W     = 50;
    localparam int H     = 50;
    localparam int NF    = 4;
    localparam int FH    = 8;
    localparam int DEPTH = W * H * NF;
    localparam int AW    = $clog2(DEPTH);
    localparam int FW    = $clog2(NF);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          vsync_tick = 1'b0;
    logic          anim_en = 1'b0;
    logic          anim_restart = 1'b0;
    logic          rd_req = 1'b0;
    logic [9:0]    rd_x = '0;
    logic [9:0]    rd_y = '0;
    logic          rd_valid;
    logic [23:0]   data_Out;
    logic          rd_in_bounds;
    logic          rd_opaque;
    logic          we = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [23:0]   data_In = '0;
    logic [FW-1:0] cur_frame;

    sprite_anim_ram #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .NUM_FRAMES (NF),
        .FRAME_HOLD (FH),
        .INIT_FILE  (""),
        .TRANSP_KEY (24'hFF00FF)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .vsync_tick    (vsync_tick),
        .anim_en       (anim_en),
        .anim_restart  (anim_restart),
        .rd_req        (rd_req),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_valid      (rd_valid),
        .data_Out      (data_Out),
        .rd_in_bounds  (rd_in_bounds),
        .rd_opaque     (rd_opaque),
        .we            (we),
        .write_address (write_address),
        .data_In       (data_In),
        .cur_frame     (cur_frame)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        logic [23:0] data;
        bit          inb;
        bit          op;
    } exp_t;

    int          test_count = 0;
    int          fail_count = 0;
    logic [23:0] ref_mem [DEPTH];
    int          ref_cnt = 0;      // enabled vsync pulses since reset/restart
    exp_t        pipe0, pipe1, held;

    function automatic int ref_frame();
        return (ref_cnt / FH) % NF;
    endfunction

    function automatic exp_t model_read(input int frame, input int x, input int y);
        exp_t e;
        e.valid = 1'b1;
        e.inb   = (x < W) && (y < H);
        e.data  = e.inb ? ref_mem[frame * W * H + y * W + x] : 24'h0;
`ifdef SPRITE_TRANSPARENCY_EN
        e.op    = e.inb && (e.data != 24'hFF00FF);
`else
        e.op    = e.inb;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, "_valid"}, 32'(rd_valid), 32'(e.valid));
        check({tag, "_data"}, 32'(data_Out), 32'(e.data));
        check({tag, "_inb"}, 32'(rd_in_bounds), 32'(e.inb));
        check({tag, "_opaque"}, 32'(rd_opaque), 32'(e.op));
    endtask

    task automatic write_word(input int a, input logic [23:0] d);
        we            = 1'b1;
        write_address = AW'(a);
        data_In       = d;
        tick();
        we            = 1'b0;
        ref_mem[a]    = d;
    endtask

    task automatic do_read(input int x, input int y, input string tag);
        exp_t e;
        e      = model_read(ref_frame(), x, y);
        rd_req = 1'b1;
        rd_x   = 10'(x);
        rd_y   = 10'(y);
        tick();
        rd_req = 1'b0;
        tick();
        check_out(tag, e);
        $display("[TB] read x=%0d y=%0d frame=%0d -> data=%h inb=%0b op=%0b", x, y, ref_frame(), data_Out, rd_in_bounds, rd_opaque);
        held = e;
    endtask

    task automatic pulse(input bit vs, input bit en, input bit rs, input string tag);
        vsync_tick   = vs;
        anim_en      = en;
        anim_restart = rs;
        tick();
        vsync_tick   = 1'b0;
        anim_restart = 1'b0;
        if (rs) ref_cnt = 0;
        else if (vs && en) ref_cnt++;
        check(tag, 32'(cur_frame), 32'(ref_frame()));
        $display("[TB] seq vs=%0b en=%0b rs=%0b -> cur_frame=%0d", vs, en, rs, cur_frame);
    endtask

    // One clock of the free-running pipeline test: check the response to
    // the request issued two steps earlier, then issue a new request.
    task automatic pipe_step(input bit req, input int x, input int y,
                             input bit vs, input bit en, input bit rs);
        tick();
        check("pipe_valid", 32'(rd_valid), 32'(pipe1.valid));
        if (pipe1.valid) begin
            check("pipe_data", 32'(data_Out), 32'(pipe1.data));
            check("pipe_inb", 32'(rd_in_bounds), 32'(pipe1.inb));
            check("pipe_opaque", 32'(rd_opaque), 32'(pipe1.op));
            held = pipe1;
        end else begin
            check("pipe_hold_data", 32'(data_Out), 32'(held.data));
            check("pipe_hold_inb", 32'(rd_in_bounds), 32'(held.inb));
        end
        check("pipe_frame", 32'(cur_frame), 32'(ref_frame()));
        $display("[TB] pipe valid=%0b data=%h inb=%0b op=%0b frame=%0d", rd_valid, data_Out, rd_in_bounds, rd_opaque, cur_frame);
        pipe1        = pipe0;
        rd_req       = req;
        rd_x         = 10'(x);
        rd_y         = 10'(y);
        vsync_tick   = vs;
        anim_en      = en;
        anim_restart = rs;
        if (req) pipe0 = model_read(ref_frame(), x, y);
        else     pipe0.valid = 1'b0;
        if (rs) ref_cnt = 0;
        else if (vs && en) ref_cnt++;
    endtask

    initial begin
        exp_t e_old;

        // ---- reset ----
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(data_Out), 32'd0);
        check("rst_inb", 32'(rd_in_bounds), 32'd0);
        check("rst_opaque", 32'(rd_opaque), 32'd0);
        check("rst_frame", 32'(cur_frame), 32'd0);
        $display("[TB] reset valid=%0b data=%h frame=%0d", rd_valid, data_Out, cur_frame);

        // ---- fill memory through the write port ----
        for (int a = 0; a < DEPTH; a++) begin
            logic [23:0] d;
            d = 24'($urandom);
            if (a == 2 * W + 3) d = 24'h123456;
            if (a == 2500)      d = 24'h0F0F0F;
            write_word(a, d);
        end
        // out-of-range write must be ignored (must not alias anything)
        we = 1'b1; write_address = AW'(DEPTH); data_In = 24'h777777;
        tick();
        we = 1'b0;

        // ---- directed reads ----
        do_read(3, 2, "px_3_2");
        check("px_3_2_literal", 32'(data_Out), 32'h123456);
        tick();
        check("hold_valid", 32'(rd_valid), 32'd0);
        check("hold_data", 32'(data_Out), 32'h123456);
        do_read(49, 49, "px_corner");
        do_read(50, 0, "oob_x50");
        do_read(0, 50, "oob_y50");
        do_read(1023, 1023, "oob_max");

        // ---- sequencer: 32 enabled pulses walk 0->1->2->3->0 ----
        for (int i = 0; i < 32; i++) begin
            pulse(1'b1, 1'b1, 1'b0, "seq_walk");
            tick();
        end
        check("seq_wrap_frame", 32'(cur_frame), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, "seq_frozen");
        pulse(1'b1, 1'b0, 1'b0, "seq_frozen");

        // ---- restart together with vsync at frame 2 ----
        for (int i = 0; i < 2 * FH; i++) pulse(1'b1, 1'b1, 1'b0, "seq_to2");
        check("seq_at2", 32'(cur_frame), 32'd2);
        pulse(1'b1, 1'b1, 1'b1, "seq_restart");
        check("seq_restart_literal", 32'(cur_frame), 32'd0);
        for (int i = 0; i < FH - 1; i++) pulse(1'b1, 1'b1, 1'b0, "seq_hold0");
        check("seq_still0", 32'(cur_frame), 32'd0);
        pulse(1'b1, 1'b1, 1'b0, "seq_after_restart");
        check("seq_now1", 32'(cur_frame), 32'd1);

        // ---- randomized back-to-back reads with a moving frame ----
        rd_req = 1'b0; vsync_tick = 1'b0; anim_restart = 1'b0;
        tick(); tick();
        pipe0.valid = 1'b0;
        pipe1.valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            pipe_step(($urandom % 5) != 0,
                      int'($urandom_range(0, 55)), int'($urandom_range(0, 55)),
                      ($urandom % 2) == 0, ($urandom % 6) != 0, ($urandom % 50) == 0);
        end
        for (int i = 0; i < 3; i++) pipe_step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        // ---- read-first collision at frame 1, (0,0) = address 2500 ----
        pulse(1'b0, 1'b0, 1'b1, "rf_restart");
        for (int i = 0; i < FH; i++) pulse(1'b1, 1'b1, 1'b0, "rf_to1");
        check("rf_frame1", 32'(cur_frame), 32'd1);
        anim_en = 1'b0;
        e_old  = model_read(1, 0, 0);
        rd_req = 1'b1; rd_x = '0; rd_y = '0;
        tick();
        rd_req = 1'b0;
        we = 1'b1; write_address = AW'(2500); data_In = 24'hABCDEF;
        tick();
        we = 1'b0;
        check_out("rf_old", e_old);
        check("rf_old_literal", 32'(data_Out), 32'h0F0F0F);
        $display("[TB] collision read -> data=%h", data_Out);
        ref_mem[2500] = 24'hABCDEF;
        do_read(0, 0, "rf_new");
        check("rf_new_literal", 32'(data_Out), 32'hABCDEF);

        // ---- transparency key pixels (frame 1) ----
        write_word(2501, 24'hFF00FF);
        write_word(2502, 24'hFF00FE);
        do_read(1, 0, "key_px");
        do_read(2, 0, "near_key_px");

        // ---- reset with a read in flight ----
        rd_req = 1'b1; rd_x = 10'd3; rd_y = 10'd2;
        tick();
        rd_req = 1'b0;
        Reset  = 1'b1;
        tick();
        check("midrst_valid", 32'(rd_valid), 32'd0);
        check("midrst_frame", 32'(cur_frame), 32'd0);
        check("midrst_data", 32'(data_Out), 32'd0);
        Reset = 1'b0;
        tick();
        check("midrst_valid_after", 32'(rd_valid), 32'd0);
        $display("[TB] reset mid-read valid=%0b frame=%0d", rd_valid, cur_frame);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
